// File: rtl/light_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : light_sample_sequencer
// Description : Scheduler for the ambient-light datapath.
//               - Every SAMPLE_PERIOD cycles it launches one serial-sensor
//                 read. It forwards each completed sample to the averaging
//                 filter as a one-cycle strobe.
//               - It shadows the colour mapper's R/G/B duty values into the
//                 PWM channels only on a PWM period boundary.
//               - It counts sensor timeouts and dropped (overrun) ticks.
//
// Ports       : clk          system clock
//               rst_n        asynchronous active-low reset
//               enable       sampling enable
//               sens_start   one-cycle pulse that begins a sensor read
//               sens_busy    sensor reader transaction in progress
//               sens_done    one-cycle pulse marking sens_data as valid
//               sens_data    sensor sample
//               filt_valid   one-cycle strobe marking filt_data as valid
//               filt_data    registered sample sent to the filter
//               red_in/green_in/blue_in     colour-mapper duty values
//               pwm_wrap     one-cycle pulse at the PWM period boundary
//               red_duty/green_duty/blue_duty  shadowed PWM duty values
//               err_timeout  one-cycle pulse on a timeout abort
//               err_cnt      saturating timeout count
//               overrun_cnt  saturating count of dropped ticks
//
// Revision    : 1.0 - initial release
// ============================================================================
module light_sample_sequencer #(
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int TIMEOUT       = 4096,
    parameter int FILT_LAT      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       sens_start,
    input  logic       sens_busy,
    input  logic       sens_done,
    input  logic [7:0] sens_data,
    output logic       filt_valid,
    output logic [7:0] filt_data,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    input  logic       pwm_wrap,
    output logic [7:0] red_duty,
    output logic [7:0] green_duty,
    output logic [7:0] blue_duty,
    output logic       err_timeout,
    output logic [7:0] err_cnt,
    output logic [7:0] overrun_cnt
);

    localparam int c_tick_w = $clog2(SAMPLE_PERIOD);
    // One spare count value so the increment on the abort cycle cannot
    // alias back onto a live compare value.
    localparam int c_to_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SAMPLE_PERIOD - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_START     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_to_w-1:0]   r_to_cnt;
    logic                r_filt_valid;
    logic [7:0]          r_filt_data;
    logic                r_err_timeout;
    logic [7:0]          r_err_cnt;
    logic [7:0]          r_ovr_cnt;
    logic                r_pending;
    logic [7:0]          r_red;
    logic [7:0]          r_green;
    logic [7:0]          r_blue;

    logic                w_tick;
    logic                w_done_hit;
    logic                w_to_hit;
    logic                w_ovr;
    logic                w_upd_ready;
    logic                w_pend_eff;

    // The tick counter is held at zero in IDLE, so it never matches there.
    assign w_tick     = (r_state != ST_IDLE) && (r_tick_cnt == c_tick_last);
    assign w_done_hit = (r_state == ST_WAIT_DONE) && sens_done;
    // A done pulse in the final cycle wins over the timeout.
    assign w_to_hit   = (r_state == ST_WAIT_DONE) && !sens_done &&
                        (r_to_cnt == c_to_last);
    // A tick is dropped while a read is in flight, or when the reader is
    // still busy. A tick that coincides with disable is not an overrun.
    assign w_ovr      = w_tick &&
                        ((r_state == ST_START) || (r_state == ST_WAIT_DONE) ||
                         ((r_state == ST_WAIT_TICK) && enable && sens_busy));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sens_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick && !sens_busy) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                sens_start  = 1'b1;
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Disable never aborts a read; it only picks the exit state.
                if (w_done_hit || w_to_hit) begin
                    w_state_nxt = enable ? ST_WAIT_TICK : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sample-period and timeout counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE || r_tick_cnt == c_tick_last) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (r_state == ST_START) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT_DONE) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample forwarding and error accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_valid  <= 1'b0;
            r_filt_data   <= 8'h00;
            r_err_timeout <= 1'b0;
            r_err_cnt     <= 8'h00;
            r_ovr_cnt     <= 8'h00;
        end else begin
            r_filt_valid  <= w_done_hit;
            r_err_timeout <= w_to_hit;
            if (w_done_hit) begin
                r_filt_data <= sens_data;
            end
            if (w_to_hit && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end
            if (w_ovr && r_ovr_cnt != 8'hFF) begin
                r_ovr_cnt <= r_ovr_cnt + 8'h01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Filter-latency delay line: upd_ready marks the cycle where the
    // colour mapper reflects the latest sample.
    // ------------------------------------------------------------------
    generate
        if (FILT_LAT == 0) begin : g_lat_zero
            assign w_upd_ready = r_filt_valid;
        end else begin : g_lat_pipe
            logic [FILT_LAT-1:0] r_dly;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= r_filt_valid;
                    for (int i = 1; i < FILT_LAT; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign w_upd_ready = r_dly[FILT_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Duty shadow registers. They load only after a PWM wrap, so a channel
    // never sees a duty change part-way through its period.
    // ------------------------------------------------------------------
    assign w_pend_eff = r_pending | w_upd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_red     <= 8'h00;
            r_green   <= 8'h00;
            r_blue    <= 8'h00;
        end else begin
            if (pwm_wrap && w_pend_eff) begin
                r_red     <= red_in;
                r_green   <= green_in;
                r_blue    <= blue_in;
                r_pending <= 1'b0;
            end else if (w_upd_ready) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign filt_valid  = r_filt_valid;
    assign filt_data   = r_filt_data;
    assign err_timeout = r_err_timeout;
    assign err_cnt     = r_err_cnt;
    assign overrun_cnt = r_ovr_cnt;
    assign red_duty    = r_red;
    assign green_duty  = r_green;
    assign blue_duty   = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_light_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_light_sample_sequencer
// Description : Self-checking bench for light_sample_sequencer.
//               - Directed scenarios cover reset, reads, timeouts, overruns,
//                 duty shadowing and the enable handshake.
//               - A randomized run is checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_light_sample_sequencer;

    localparam int P  = 16;
    localparam int TO = 8;
    localparam int FL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       sens_busy = 1'b0;
    logic       sens_done = 1'b0;
    logic       pwm_wrap = 1'b0;
    logic [7:0] sens_data = 8'h00;
    logic [7:0] red_in = 8'h00;
    logic [7:0] green_in = 8'h00;
    logic [7:0] blue_in = 8'h00;
    logic       sens_start;
    logic       filt_valid;
    logic       err_timeout;
    logic [7:0] filt_data;
    logic [7:0] red_duty;
    logic [7:0] green_duty;
    logic [7:0] blue_duty;
    logic [7:0] err_cnt;
    logic [7:0] overrun_cnt;

    int checks = 0;
    int errors = 0;

    light_sample_sequencer #(
        .SAMPLE_PERIOD(P),
        .TIMEOUT      (TO),
        .FILT_LAT     (FL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sens_start (sens_start),
        .sens_busy  (sens_busy),
        .sens_done  (sens_done),
        .sens_data  (sens_data),
        .filt_valid (filt_valid),
        .filt_data  (filt_data),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .pwm_wrap   (pwm_wrap),
        .red_duty   (red_duty),
        .green_duty (green_duty),
        .blue_duty  (blue_duty),
        .err_timeout(err_timeout),
        .err_cnt    (err_cnt),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bounded wait for the next read launch.
    task automatic wait_start();
        int n = 0;
        while (sens_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (sens_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_start: sens_start=%b after %0d cycles, expected 1", sens_start, n);
        end
    endtask

    // Enable is raised just before this is called; the read must launch on
    // the 17th clock edge and not before.
    task automatic check_first_start(input string name);
        for (int k = 1; k <= P + 1; k++) begin
            step();
            checks++;
            if (sens_start !== 1'(k == P + 1)) begin
                errors++;
                $display("FAIL %s: edge %0d sens_start=%b, expected %b", name, k, sens_start, (k == P + 1));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sens_start, filt_valid, err_timeout, filt_data, red_duty, green_duty, blue_duty, err_cnt, overrun_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_values: outputs=%h, expected all zero",
                     {sens_start, filt_valid, err_timeout, filt_data, red_duty, green_duty, blue_duty, err_cnt, overrun_cnt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        check_first_start("first_start");
    endtask

    task automatic test_normal_read();
        sens_busy = 1'b1;
        step();
        checks++;
        if (sens_start !== 1'b0) begin
            errors++;
            $display("FAIL start_one_cycle: sens_start=%b, expected 0", sens_start);
        end
        step();
        step();
        checks++;
        if (filt_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_early_valid: filt_valid=%b, expected 0", filt_valid);
        end
        sens_done = 1'b1;
        sens_data = 8'hA5;
        step();
        checks++;
        if (filt_valid !== 1'b1 || filt_data !== 8'hA5 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL read_strobe: valid=%b data=%h to=%b, expected 1 a5 0", filt_valid, filt_data, err_timeout);
        end
        sens_done = 1'b0;
        sens_busy = 1'b0;
        sens_data = 8'h00;
        step();
        checks++;
        if (filt_valid !== 1'b0 || filt_data !== 8'hA5 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL read_hold: valid=%b data=%h err_cnt=%0d, expected 0 a5 0", filt_valid, filt_data, err_cnt);
        end
    endtask

    task automatic test_timeout();
        wait_start();
        sens_busy = 1'b1;
        for (int k = 1; k <= TO + 1; k++) begin
            step();
            checks++;
            if (err_timeout !== 1'(k == TO + 1) || filt_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_pulse: cycle %0d err_timeout=%b filt_valid=%b, expected %b 0",
                         k, err_timeout, filt_valid, (k == TO + 1));
            end
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL timeout_cnt: err_cnt=%0d, expected 1", err_cnt);
        end
        sens_busy = 1'b0;
        step();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_one_cycle: err_timeout=%b, expected 0", err_timeout);
        end
        // Completion arrives in the very last allowed cycle.
        wait_start();
        sens_busy = 1'b1;
        repeat (TO) step();
        sens_done = 1'b1;
        sens_data = 8'h3C;
        step();
        checks++;
        if (filt_valid !== 1'b1 || filt_data !== 8'h3C || err_timeout !== 1'b0 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL done_at_timeout: valid=%b data=%h to=%b err_cnt=%0d, expected 1 3c 0 1",
                     filt_valid, filt_data, err_timeout, err_cnt);
        end
        sens_done = 1'b0;
        sens_busy = 1'b0;
    endtask

    task automatic test_overrun();
        int starts = 0;
        checks++;
        if (overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL overrun_initial: overrun_cnt=%0d, expected 0", overrun_cnt);
        end
        sens_busy = 1'b1;
        repeat (3 * P) begin
            step();
            if (sens_start === 1'b1) starts++;
        end
        checks++;
        if (overrun_cnt !== 8'd3 || starts != 0) begin
            errors++;
            $display("FAIL overrun_three: overrun_cnt=%0d starts=%0d, expected 3 0", overrun_cnt, starts);
        end
        repeat (300 * P) begin
            step();
            if (sens_start === 1'b1) starts++;
        end
        checks++;
        if (overrun_cnt !== 8'd255 || starts != 0) begin
            errors++;
            $display("FAIL overrun_saturate: overrun_cnt=%0d starts=%0d, expected 255 0", overrun_cnt, starts);
        end
        sens_busy = 1'b0;
    endtask

    task automatic test_duty_shadow();
        // Earlier samples left an update pending, so the first wrap loads.
        red_in = 8'h11;
        green_in = 8'h22;
        blue_in = 8'h33;
        pwm_wrap = 1'b1;
        step();
        pwm_wrap = 1'b0;
        checks++;
        if ({red_duty, green_duty, blue_duty} !== 24'h112233) begin
            errors++;
            $display("FAIL duty_pending_load: duties=%h, expected 112233", {red_duty, green_duty, blue_duty});
        end
        wait_start();
        red_in = 8'h40;
        green_in = 8'h50;
        blue_in = 8'h60;
        sens_busy = 1'b1;
        step();
        sens_done = 1'b1;
        sens_data = 8'h77;
        step();
        checks++;
        if (filt_valid !== 1'b1) begin
            errors++;
            $display("FAIL duty_sample: filt_valid=%b, expected 1", filt_valid);
        end
        sens_done = 1'b0;
        sens_busy = 1'b0;
        step();
        pwm_wrap = 1'b1;
        step();
        pwm_wrap = 1'b0;
        checks++;
        if (red_duty !== 8'h11) begin
            errors++;
            $display("FAIL duty_early_wrap: red_duty=%h, expected 11", red_duty);
        end
        step();
        step();
        pwm_wrap = 1'b1;
        checks++;
        if (red_duty !== 8'h11) begin
            errors++;
            $display("FAIL duty_before_wrap: red_duty=%h, expected 11", red_duty);
        end
        step();
        pwm_wrap = 1'b0;
        checks++;
        if ({red_duty, green_duty, blue_duty} !== 24'h405060) begin
            errors++;
            $display("FAIL duty_load: duties=%h, expected 405060", {red_duty, green_duty, blue_duty});
        end
        red_in = 8'h99;
        step();
        step();
        pwm_wrap = 1'b1;
        step();
        pwm_wrap = 1'b0;
        step();
        checks++;
        if (red_duty !== 8'h40) begin
            errors++;
            $display("FAIL duty_hold: red_duty=%h, expected 40", red_duty);
        end
    endtask

    task automatic test_enable_drop();
        int starts = 0;
        wait_start();
        sens_busy = 1'b1;
        step();
        enable = 1'b0;
        step();
        step();
        sens_done = 1'b1;
        sens_data = 8'hC3;
        step();
        checks++;
        if (filt_valid !== 1'b1 || filt_data !== 8'hC3) begin
            errors++;
            $display("FAIL disable_finish: valid=%b data=%h, expected 1 c3", filt_valid, filt_data);
        end
        sens_done = 1'b0;
        sens_busy = 1'b0;
        repeat (40) begin
            step();
            if (sens_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL disable_idle: %0d starts while disabled, expected 0", starts);
        end
        enable = 1'b1;
        check_first_start("reenable_start");
    endtask

    task automatic test_reset_async();
        sens_busy = 1'b1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sens_start, filt_valid, err_timeout, filt_data, red_duty, green_duty, blue_duty, err_cnt, overrun_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h, expected all zero",
                     {sens_start, filt_valid, err_timeout, filt_data, red_duty, green_duty, blue_duty, err_cnt, overrun_cnt});
        end
        sens_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_first_start("post_reset_start");
    endtask

    // Randomized traffic against a transaction-level model.
    // m_rd: -1 = no read in flight, 0 = launch cycle, k>0 = k-th cycle awaiting data.
    task automatic test_random();
        int         m_age = 0;
        int         m_rd = -1;
        int         m_cyc = 0;
        bit         m_run = 0;
        bit         m_fv = 0;
        bit         m_et = 0;
        bit         m_pend = 0;
        bit [7:0]   m_fd = 0;
        bit [7:0]   m_errc = 0;
        bit [7:0]   m_ovc = 0;
        bit [23:0]  m_duty = 0;
        int         upd_q[$];
        int         rd_left = 0;
        bit         rd_busy = 0;
        bit         ext_busy = 0;
        bit         tick;
        bit         ovr;
        bit         upd;
        bit         n_fv;
        bit         n_et;
        int         nfail = 0;

        rst_n = 1'b0;
        enable = 1'b1;
        sens_busy = 1'b0;
        sens_done = 1'b0;
        pwm_wrap = 1'b0;
        red_in = 8'h00;
        green_in = 8'h00;
        blue_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (sens_start !== 1'(m_rd == 0) || filt_valid !== m_fv || filt_data !== m_fd ||
                err_timeout !== m_et || err_cnt !== m_errc || overrun_cnt !== m_ovc ||
                {red_duty, green_duty, blue_duty} !== m_duty) begin
                errors++;
                nfail++;
                if (nfail <= 10)
                    $display("FAIL random_cycle %0d: st=%b fv=%b fd=%h to=%b ec=%0d oc=%0d duty=%h, expected %b %b %h %b %0d %0d %h",
                             c, sens_start, filt_valid, filt_data, err_timeout, err_cnt, overrun_cnt,
                             {red_duty, green_duty, blue_duty}, (m_rd == 0), m_fv, m_fd, m_et, m_errc, m_ovc, m_duty);
            end
            checks++;
            if (sens_start === 1'b1 && sens_busy === 1'b1) begin
                errors++;
                $display("FAIL random_start_busy: sens_start asserted with sens_busy at cycle %0d", c);
            end

            // Emulated sensor reader: random latency 1..10, beyond TO times out.
            if (m_rd == 0) begin
                rd_left = $urandom_range(1, 10);
                rd_busy = 1'b0;
                sens_done = 1'b0;
            end else if (rd_left > 0) begin
                rd_left--;
                rd_busy = 1'b1;
                sens_done = (rd_left == 0);
                sens_data = 8'($urandom);
            end else begin
                rd_busy = 1'b0;
                sens_done = 1'b0;
            end
            if (m_rd < 0 && $urandom_range(0, 19) == 0) ext_busy = ~ext_busy;
            sens_busy = rd_busy | ext_busy;
            pwm_wrap = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                red_in = 8'($urandom);
                green_in = 8'($urandom);
                blue_in = 8'($urandom);
            end

            @(posedge clk);
            tick = m_run && ((m_age % P) == P - 1);
            ovr = tick && (m_rd >= 0 || sens_busy);
            n_fv = 0;
            n_et = 0;
            if (m_rd >= 1) begin
                if (sens_done) begin
                    n_fv = 1;
                    m_fd = sens_data;
                    m_rd = -1;
                end else if (m_rd == TO) begin
                    n_et = 1;
                    if (m_errc != 8'hFF) m_errc++;
                    m_rd = -1;
                end else begin
                    m_rd++;
                end
            end else if (m_rd == 0) begin
                m_rd = 1;
            end else if (tick && !sens_busy) begin
                m_rd = 0;
            end
            if (ovr && m_ovc != 8'hFF) m_ovc++;
            upd = (upd_q.size() > 0 && upd_q[0] == m_cyc);
            if (upd) void'(upd_q.pop_front());
            if (pwm_wrap && (m_pend || upd)) begin
                m_duty = {red_in, green_in, blue_in};
                m_pend = 0;
            end else if (upd) begin
                m_pend = 1;
            end
            if (n_fv) upd_q.push_back(m_cyc + 1 + FL);
            m_fv = n_fv;
            m_et = n_et;
            if (m_run) m_age++;
            else begin
                m_run = 1;
                m_age = 0;
            end
            m_cyc++;
            @(negedge clk);
        end
        sens_busy = 1'b0;
        sens_done = 1'b0;
        pwm_wrap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_read();
        test_timeout();
        test_overrun();
        test_duty_shadow();
        test_enable_drop();
        test_reset_async();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/light_sample_sequencer.md
Name: light_sample_sequencer

Overview:
Scheduler for the ambient-light datapath. Periodically triggers one read of the serial light sensor and forwards each completed sample to the averaging filter as a one-cycle valid strobe. Shadow-loads the colour mapper's R/G/B duty values into the three PWM channels only on a PWM period boundary, so duty changes never glitch mid-period. Detects sensor timeouts and sampling overruns.

Parameters:
SAMPLE_PERIOD, 1000000, clock cycles between sample ticks (min 4)
TIMEOUT, 4096, max cycles from sens_start to sens_done before abort (min 2)
FILT_LAT, 2, cycles from filt_valid until colour-mapper outputs reflect the new sample (0..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  sampling enable
sens_start  out  1  one-cycle pulse: begin sensor read
sens_busy  in  1  sensor reader transaction in progress
sens_done  in  1  one-cycle pulse: sens_data valid
sens_data  in  8  sensor sample
filt_valid  out  1  one-cycle strobe: filt_data valid to filter
filt_data  out  8  registered sample to filter
red_in / green_in / blue_in  in  8 each  colour-mapper duty values
pwm_wrap  in  1  one-cycle pulse at the PWM counter period boundary
red_duty / green_duty / blue_duty  out  8 each  shadowed duty values to the PWM channels
err_timeout  out  1  one-cycle pulse on timeout abort
err_cnt  out  8  saturating timeout count
overrun_cnt  out  8  saturating count of dropped ticks

Behaviour:
- Reset, async on rst_n low: state IDLE; all outputs 0; all counters 0; pending flag 0.
- Tick counter: cleared in IDLE. Otherwise counts 0..SAMPLE_PERIOD-1 and wraps. tick = 1 in the cycle the count equals SAMPLE_PERIOD-1. The first tick comes SAMPLE_PERIOD cycles after leaving IDLE.
- FSM states: IDLE, WAIT_TICK, START, WAIT_DONE.
- IDLE: enable=1 -> WAIT_TICK.
- WAIT_TICK:
  - enable=0 -> IDLE (takes priority over tick).
  - tick and sens_busy=0 -> START.
  - tick and sens_busy=1 -> overrun_cnt+1 (saturates at 255); remain in WAIT_TICK.
- START: sens_start=1 for exactly this cycle; timeout counter cleared; -> WAIT_DONE.
- WAIT_DONE: timeout counter increments each cycle.
  - sens_done=1 -> next cycle filt_data=sens_data, filt_valid=1 for one cycle; -> WAIT_TICK, or IDLE if enable=0.
  - Timeout counter reaches TIMEOUT-1 with no sens_done -> err_timeout pulse next cycle, err_cnt+1 (saturating), no filt_valid; -> WAIT_TICK or IDLE as above.
  - sens_done in the same cycle as timeout: treated as done, no error.
  - enable dropping mid-transaction does not abort the read; the read completes or times out first.
- Ticks arriving in START or WAIT_DONE increment overrun_cnt and are dropped. No tick is queued.
- filt_data holds its value between strobes.
- Duty shadowing:
  - A delay line asserts upd_ready FILT_LAT cycles after filt_valid (FILT_LAT=0: same cycle). upd_ready sets the pending flag.
  - On pwm_wrap with pending=1 (including pending being set in that same cycle): red/green/blue_duty load red/green/blue_in the next cycle, and pending clears.
  - pwm_wrap with pending=0: duties hold.
  - Duties change only on the cycle after pwm_wrap. They are unaffected by enable.
- sens_start is never asserted while sens_busy=1.

Test Plan:
(SAMPLE_PERIOD=16, TIMEOUT=8, FILT_LAT=2 for all scenarios.)
1. Reset mid-WAIT_DONE: rst_n low -> all outputs 0 immediately; after release with enable=1, first sens_start exactly 17 cycles after leaving IDLE.
2. Normal read: sens_done 3 cycles after sens_start with sens_data=0xA5 -> filt_valid one cycle with filt_data=0xA5; err_cnt stays 0.
3. Timeout: no sens_done -> err_timeout pulse 8 cycles after WAIT_DONE entry; err_cnt=1; no filt_valid. sens_done coincident with the timeout edge -> filt_valid, err_cnt unchanged.
4. Overrun: hold sens_busy=1 across 3 ticks -> overrun_cnt=3, no sens_start; drive 300 dropped ticks -> overrun_cnt saturates at 255.
5. Duty shadow: red_in=0x40 after a sample, pwm_wrap at 1 cycle after filt_valid -> no load; next pwm_wrap -> red_duty=0x40 the following cycle. A further pwm_wrap with no new sample -> duty holds while red_in changes.
6. enable deasserted during WAIT_DONE -> transaction finishes (filt_valid), FSM goes to IDLE, no further sens_start; re-enable -> next sens_start 17 cycles later.
